// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI initiator: FSM state encoding,
// counter-width functions and the fixed bus mode.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_LAG,
    S_GAP
  } spi_init_state_t;

  // Mode 0: SCK idles low, data captured on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int SPI_DATA_W_DEF = 8;
  localparam int SPI_DIV_DEF    = 4;

  function automatic int bit_cnt_w(input int data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

  function automatic int div_cnt_w(input int div);
    return (div < 1) ? 1 : $clog2(div + 1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter: load DIV-1 on a state change, count down to zero,
// terminal count flags the last cycle of the current phase.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV = SPI_DIV_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  output logic o_tc
);

  localparam int            CW       = div_cnt_w(DIV);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)            r_cnt <= '0;
    else if (i_load)         r_cnt <= LOAD_VAL;
    else if (r_cnt != '0)    r_cnt <= r_cnt - CW'(1);
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/spi_initiator.sv
// SPI mode-0 initiator, MSB first: serialises stream words onto SCK/MOSI/CS_n
// and returns the word captured on MISO. All outputs are registered.
module spi_initiator
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF,
  parameter int DIV    = SPI_DIV_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_last,
  output logic              o_rx_valid,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_busy,
  output logic              o_sck,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_cs_n
);

  localparam int            BW       = bit_cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_init_state_t   r_state, w_next;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_tx_sr, r_rx_sr, r_rx_data;
  logic              r_last, r_sck, r_cs_n, r_mosi, r_tx_ready, r_rx_valid, r_busy;
  logic              w_tc, w_accept, w_load, w_bit_end, w_word_end;

  assign w_accept   = i_tx_valid & r_tx_ready;
  assign w_load     = (w_next != r_state);
  assign w_bit_end  = (r_state == S_HIGH) & w_tc;
  assign w_word_end = (r_state == S_LOW) & w_tc & (r_bit == LAST_BIT);

  spi_clk_div #(.DIV(DIV)) u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .o_tc    (w_tc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_LEAD;
      S_LEAD:  if (w_tc)     w_next = S_HIGH;
      S_HIGH:  if (w_tc)     w_next = S_LOW;
      S_LOW:   if (w_tc)     w_next = (r_bit != LAST_BIT) ? S_HIGH :
                                      (r_last ? S_LAG : S_HOLD);
      S_HOLD:  if (w_accept) w_next = S_LEAD;
      S_LAG:   if (w_tc)     w_next = S_GAP;
      S_GAP:   if (w_tc)     w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  // Pin-level outputs are decoded from the next state so they change
  // on the same edge as the state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sck      <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_bit      <= '0;
      r_last     <= 1'b0;
    end else begin
      r_sck      <= (w_next == S_HIGH);
      r_cs_n     <= (w_next == S_IDLE) || (w_next == S_GAP);
      r_tx_ready <= (w_next == S_IDLE) || (w_next == S_HOLD);
      r_busy     <= (w_next != S_IDLE);
      r_rx_valid <= w_word_end;
      if (w_accept) begin
        r_tx_sr <= i_tx_data;
        r_last  <= i_tx_last;
        r_mosi  <= i_tx_data[DATA_W-1];
        r_bit   <= '0;
      end
      // MISO is sampled DIV cycles after the rise; MOSI holds after the last bit.
      if (w_bit_end) begin
        r_rx_sr <= {r_rx_sr[DATA_W-2:0], i_miso};
        if (r_bit != LAST_BIT) begin
          r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
          r_mosi  <= r_tx_sr[DATA_W-2];
        end
      end
      if ((r_state == S_LOW) && w_tc && (r_bit != LAST_BIT))
        r_bit <= r_bit + BW'(1);
      if (w_word_end)
        r_rx_data <= r_rx_sr;
    end
  end

  assign o_sck      = r_sck;
  assign o_cs_n     = r_cs_n;
  assign o_mosi     = r_mosi;
  assign o_tx_ready = r_tx_ready;
  assign o_busy     = r_busy;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_initiator.sv
// Directed bench: loopback DUT (DATA_W=8, DIV=4) and a MISO-high DUT (DIV=1),
// event timing measured in cycles after the accept edge.
module tb_spi_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, a_valid, a_last, b_valid, b_last;
  logic [7:0] a_data, b_data;
  logic       a_ready, a_rxv, a_busy, a_sck, a_mosi, a_cs;
  logic [7:0] a_rxd;
  logic       b_ready, b_rxv, b_busy, b_sck, b_mosi, b_cs;
  logic [7:0] b_rxd;

  spi_initiator #(.DATA_W(8), .DIV(4)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(a_valid), .o_tx_ready(a_ready),
    .i_tx_data(a_data), .i_tx_last(a_last), .o_rx_valid(a_rxv), .o_rx_data(a_rxd),
    .o_busy(a_busy), .o_sck(a_sck), .o_mosi(a_mosi), .i_miso(a_mosi), .o_cs_n(a_cs));

  spi_initiator #(.DATA_W(8), .DIV(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(b_valid), .o_tx_ready(b_ready),
    .i_tx_data(b_data), .i_tx_last(b_last), .o_rx_valid(b_rxv), .o_rx_data(b_rxd),
    .o_busy(b_busy), .o_sck(b_sck), .o_mosi(b_mosi), .i_miso(1'b1), .o_cs_n(b_cs));

  int n_cmp = 0, n_bad = 0;
  int pe = 0;
  always @(posedge clk) pe = pe + 1;

  // Monitor for DUT A; counters restart whenever epoch changes.
  int epoch = 0, seen_epoch = 0;
  int rel, pe_acc, n_acc, n_rise, n_rise_cs, n_rxv, n_csr, n_hold, hold_bad;
  int first_rise, rxv_cyc, cs_rise, rdy_rise;
  logic [7:0] tx_cap;
  logic p_sck = 1'b0, p_cs = 1'b1, p_rdy = 1'b1;
  int rxq[$];

  always @(negedge clk) begin
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      n_acc = 0; n_rise = 0; n_rise_cs = 0; n_rxv = 0; n_csr = 0;
      n_hold = 0; hold_bad = 0; first_rise = -1; rxv_cyc = -1;
      cs_rise = -1; rdy_rise = -1; tx_cap = '0; pe_acc = pe;
      rxq.delete();
    end
    rel = pe - pe_acc;
    if (a_sck && !p_sck) begin
      n_rise++;
      if (n_rise == 1) first_rise = rel;
      if (!a_cs) n_rise_cs++;
      tx_cap = {tx_cap[6:0], a_mosi};
    end
    if (a_rxv) begin n_rxv++; rxv_cyc = rel; rxq.push_back(int'(a_rxd)); end
    if (a_cs && !p_cs) begin n_csr++; cs_rise = rel; end
    if (a_ready && !p_rdy) rdy_rise = rel;
    if (a_busy && a_ready) begin
      n_hold++;
      if (a_cs || a_sck) hold_bad++;
    end
    if (a_valid && a_ready) begin
      n_acc++;
      if (n_acc == 1) pe_acc = pe;
    end
    p_sck = a_sck; p_cs = a_cs; p_rdy = a_ready;
  end

  // Monitor for DUT B (single transfer).
  int b_acc = -1, b_rise1 = -1, b_rise2 = -1, b_nrise = 0, b_nrxv = 0, b_rxv_cyc = -1, b_mosi1 = 0;
  logic bp_sck = 1'b0;
  always @(negedge clk) begin
    if (b_sck && !bp_sck) begin
      b_nrise++;
      if (b_nrise == 1) b_rise1 = pe - b_acc;
      if (b_nrise == 2) b_rise2 = pe - b_acc;
    end
    if (b_rxv) begin b_nrxv++; b_rxv_cyc = pe - b_acc; end
    if (b_mosi) b_mosi1++;
    if (b_valid && b_ready && b_acc < 0) b_acc = pe;
    bp_sck = b_sck;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    epoch++;
    tick(1);
  endtask

  function automatic int rxq_at(input int i);
    return (rxq.size() > i) ? rxq[i] : -1;
  endfunction

  task automatic send_a(input logic [7:0] d, input logic last);
    a_valid = 1'b1; a_data = d; a_last = last;
    tick(1);
    a_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    tick(3);
    chk("rst_cs_n", a_cs, 1);
    chk("rst_sck", a_sck, 0);
    chk("rst_mosi", a_mosi, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_rx_valid", a_rxv, 0);
    chk("rst_rx_data", a_rxd, 0);
    rst_n = 1'b1;
    tick(2);

    // Single word 0xA5, loopback
    clr();
    send_a(8'hA5, 1'b1);
    tick(90);
    chk("a5_rises", n_rise, 8);
    chk("a5_first_rise", first_rise, 5);
    chk("a5_rxv_count", n_rxv, 1);
    chk("a5_rxv_cycle", rxv_cyc, 69);
    chk("a5_rx_data", rxq_at(0), 8'hA5);
    chk("a5_mosi_bits", tx_cap, 8'hA5);
    chk("a5_cs_rise", cs_rise, 73);
    chk("a5_ready_rise", rdy_rise, 77);

    // Held-CS burst 0x3C then 0xC3
    clr();
    a_valid = 1'b1; a_data = 8'h3C; a_last = 1'b0;
    tick(1);
    a_data = 8'hC3; a_last = 1'b1;
    for (int i = 0; i < 200 && n_acc < 2; i++) tick(1);
    a_valid = 1'b0;
    tick(100);
    chk("burst_accepts", n_acc, 2);
    chk("burst_rises", n_rise, 16);
    chk("burst_rises_cs_low", n_rise_cs, 16);
    chk("burst_cs_rises", n_csr, 1);
    chk("burst_rxv_count", n_rxv, 2);
    chk("burst_rx0", rxq_at(0), 8'h3C);
    chk("burst_rx1", rxq_at(1), 8'hC3);
    chk("burst_hold_cycles", n_hold, 1);

    // DIV=1, MISO high, send 0x00
    b_valid = 1'b1; b_data = 8'h00; b_last = 1'b1;
    tick(1);
    b_valid = 1'b0;
    tick(30);
    chk("div1_sck_period", b_rise2 - b_rise1, 2);
    chk("div1_rises", b_nrise, 8);
    chk("div1_rxv_count", b_nrxv, 1);
    chk("div1_rxv_cycle", b_rxv_cyc, 18);
    chk("div1_rx_data", b_rxd, 8'hFF);
    chk("div1_mosi_ones", b_mosi1, 0);

    // tx_valid held with changing data while busy
    clr();
    a_valid = 1'b1; a_data = 8'h96; a_last = 1'b1;
    for (int i = 0; i < 71; i++) begin
      tick(1);
      a_data = 8'(i * 37 + 1);
      a_last = i[0];
    end
    a_valid = 1'b0;
    tick(20);
    chk("held_accepts", n_acc, 1);
    chk("held_mosi_bits", tx_cap, 8'h96);
    chk("held_rx_data", rxq_at(0), 8'h96);
    chk("held_cs_rises", n_csr, 1);

    // Reset after the 3rd SCK rise drops the word
    clr();
    send_a(8'hFF, 1'b1);
    for (int i = 0; i < 100 && n_rise < 3; i++) tick(1);
    chk("rstmid_reached_rise3", n_rise, 3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rstmid_cs_n", a_cs, 1);
    chk("rstmid_sck", a_sck, 0);
    chk("rstmid_mosi", a_mosi, 0);
    chk("rstmid_busy", a_busy, 0);
    chk("rstmid_ready", a_ready, 1);
    tick(100);
    chk("rstmid_no_rxv", n_rxv, 0);
    clr();
    send_a(8'h5A, 1'b1);
    tick(90);
    chk("post_rst_rxv", n_rxv, 1);
    chk("post_rst_rx", rxq_at(0), 8'h5A);
    chk("post_rst_mosi_bits", tx_cap, 8'h5A);
    chk("post_rst_cs_rises", n_csr, 1);

    // Long HOLD, then final word releases CS
    clr();
    send_a(8'h81, 1'b0);
    tick(168);
    chk("hold_rxv_first", n_rxv, 1);
    chk("hold_rx0", rxq_at(0), 8'h81);
    chk("hold_bad_cycles", hold_bad, 0);
    chk("hold_cs_rises", n_csr, 0);
    send_a(8'h7E, 1'b1);
    tick(90);
    chk("hold_total_cycles", n_hold, 101);
    chk("hold_rxv_count", n_rxv, 2);
    chk("hold_rx1", rxq_at(1), 8'h7E);
    chk("hold_release", n_csr, 1);
    chk("hold_final_cs", a_cs, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_initiator.md
# spi_initiator

SPI bus initiator (mode 0, MSB first) that serialises words from a valid/ready stream onto SCK/MOSI/CS_n and returns the words captured on MISO. It sits on the initiator side of the cosim SPI path and drives the SPI responder models in the DVT bench, including the loopback responder. It is synthesizable and intended for reuse as a lightweight on-chip SPI master.

## Interface
- DATA_W, 8: bits per word, ≥2.
- DIV, 4: clk cycles per SCK half-period, ≥1.

- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- tx_valid  in  1  word offered.
- tx_ready  out  1  block can accept a word.
- tx_data  in  DATA_W  word to send, MSB first.
- tx_last  in  1  1 = deassert CS_n after this word; 0 = hold CS_n low for the next word.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- rx_data  out  DATA_W  word captured on MISO, MSB first.
- busy  out  1  high in every state except IDLE.
- SCK  out  1  SPI clock, idles low.
- MOSI  out  1  serial data to responder.
- MISO  in  1  serial data from responder.
- CS_n  out  1  chip select, active-low.

## Operation
- One clock; reset is synchronous and active-low. rst_n low at a clk edge forces: state IDLE, SCK=0, CS_n=1, MOSI=0, tx_ready=1 (after reset releases), rx_valid=0, rx_data=0, busy=0, counters cleared.
- States: IDLE, LEAD, HIGH, LOW, HOLD, LAG, GAP.
- Accept = tx_valid & tx_ready at a clk edge. tx_data/tx_last are latched at accept; later changes are ignored. tx_valid while tx_ready=0 is ignored, with no side effect.
- tx_ready=1 only in IDLE and HOLD.
- IDLE --accept--> LEAD: CS_n=0, MOSI=tx_data[DATA_W-1].
- LEAD (DIV cycles) -> HIGH.
- HIGH (DIV cycles, SCK=1) -> LOW.
- On the edge leaving HIGH:
  - MISO is sampled into the rx shift register.
  - MOSI advances to the next bit, except after the final bit, where MOSI holds.
- LOW (DIV cycles, SCK=0) -> HIGH while bits remain; after bit DATA_W-1, go to LAG if the latched tx_last=1, else HOLD.
- rx_valid pulses for exactly one cycle: the first cycle of LAG or HOLD. rx_data is stable until the next pulse.
- HOLD: CS_n=0, SCK=0, waits without limit; accept -> LEAD with the new MSB on MOSI.
- LAG (DIV cycles, CS_n=0) -> GAP: CS_n=1.
- GAP (DIV cycles) -> IDLE.
- A reset mid-word drops the word: no rx_valid is generated, and CS_n=1 on the cycle after the reset edge.
- Bit counter width is $clog2(DATA_W). Divider counter width is $clog2(DIV+1). The divider counts DIV-1 down to 0; a state transition occurs on terminal count.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Accept at edge E0; cycles are numbered after E0.
- CS_n falls and MOSI=MSB at cycle 1.
- Bit i (0 = MSB): SCK high in cycles (2i+1)·DIV+1 … (2i+2)·DIV, low in the next DIV cycles.
- rx_valid occurs at cycle (2·DATA_W+1)·DIV+1.
- tx_last=1: CS_n rises at (2·DATA_W+2)·DIV+1; tx_ready returns at (2·DATA_W+3)·DIV+1.
- MOSI is set up DIV cycles before each SCK rise. MISO is sampled DIV cycles after each SCK rise, which tolerates responders that update MISO on the rising edge.
- Throughput in a held-CS burst: one word per (2·DATA_W+1)·DIV+1 cycles, plus any cycles spent in HOLD.

## Structure
- Package spi_pkg:
  - state enum spi_init_state_t;
  - localparams for counter widths;
  - shared mode constants (CPOL=0, CPHA=0).
- One sub-module, spi_clk_div: half-period counter with load and terminal-count output. The FSM and shift registers stay in spi_initiator.

## Test plan
- Loopback responder attached, DATA_W=8, DIV=4, send 0xA5 with tx_last=1:
  - exactly 8 SCK rises, first at cycle 5;
  - rx_valid only at cycle 69 with rx_data=0xA5;
  - CS_n high at cycle 73; tx_ready at cycle 77.
- Burst 0x3C (tx_last=0) then 0xC3 (tx_last=1), offered back to back:
  - CS_n continuously low across 16 SCK rises;
  - rx_data=0x3C, then 0xC3;
  - one HOLD cycle between the words.
- MISO tied 1, DIV=1, send 0x00: SCK period is 2 clk cycles; rx_data=0xFF; MOSI stays 0.
- tx_valid held high with changing tx_data while busy: only the word latched at accept is transmitted; no extra accepts occur.
- rst_n low for one cycle after the 3rd SCK rise:
  - next cycle shows CS_n=1, SCK=0, MOSI=0, busy=0, tx_ready=1;
  - no rx_valid;
  - a following 0x5A transfer completes correctly.
- HOLD with tx_valid=0 for 100 cycles: CS_n stays 0, SCK stays 0, no rx_valid; a later word with tx_last=1 completes and releases CS_n.
